// File: rtl/qpp_interleaver.sv
// Turbo-encoder feeder: buffers one code block, then replays it in natural (ck) and QPP-interleaved (ckp) order.
// Optional macro INTLV_BYPASS_EN adds a 'bypass' input that forces ckp to natural order for the block.
module qpp_interleaver #(
    parameter int K0    = 1056,
    parameter int F1_0  = 17,
    parameter int F2_0  = 66,
    parameter int K1    = 16,
    parameter int F1_1  = 1,
    parameter int F2_1  = 4,
    parameter int GUARD = 4
) (
    input  logic clk,
    input  logic aclr,
    input  logic K,
    input  logic in_bit,
    input  logic in_valid,
`ifdef INTLV_BYPASS_EN
    input  logic bypass,
`endif
    output logic in_ready,
    input  logic enc_busy,
    output logic data_ready,
    output logic ck,
    output logic ckp,
    output logic active
);

    localparam int AW = $clog2(K0);
    localparam int GW = $clog2(GUARD + 1);

    localparam logic [AW-1:0] KSEL_0 = AW'(K0);
    localparam logic [AW-1:0] KSEL_1 = AW'(K1);
    localparam logic [AW-1:0] G0_0   = AW'((F1_0 + F2_0) % K0);
    localparam logic [AW-1:0] G0_1   = AW'((F1_1 + F2_1) % K1);
    localparam logic [AW-1:0] STEP_0 = AW'((2 * F2_0) % K0);
    localparam logic [AW-1:0] STEP_1 = AW'((2 * F2_1) % K1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_OUT, S_GUARD} state_t;

    state_t         state_reg;
    logic [AW-1:0]  ksel_reg;
    logic [AW-1:0]  g0_reg;
    logic [AW-1:0]  step_reg;
    logic [AW-1:0]  wr_cnt_reg;
    logic [AW-1:0]  i_reg;
    logic [AW-1:0]  pi_reg;
    logic [AW-1:0]  g_reg;
    logic [GW-1:0]  guard_cnt_reg;
    logic           data_ready_reg;
    logic           active_reg;
    logic           bypass_reg;

    logic           accept;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  i_next;
    logic [AW-1:0]  pi_next;
    logic [AW-1:0]  pi_mod;
    logic [AW-1:0]  g_next;
    logic [AW:0]    pi_sum;
    logic [AW:0]    g_sum;
    logic           last_bit;
    logic [1:0][AW-1:0] rd_addr;

    logic buf_mem [0:K0-1];

    assign in_ready = ((state_reg == S_IDLE) || (state_reg == S_LOAD)) && !aclr;
    assign accept   = in_valid && in_ready;
    assign wr_en    = accept;
    assign wr_addr  = (state_reg == S_IDLE) ? '0 : wr_cnt_reg;
    assign last_bit = (i_reg == ksel_reg - AW'(1));

    // Both recurrences keep operands below Ksel, so one conditional subtract wraps them.
    always_comb begin
        pi_sum = {1'b0, pi_reg} + {1'b0, g_reg};
        g_sum  = {1'b0, g_reg} + {1'b0, step_reg};
        if (pi_sum >= {1'b0, ksel_reg})
            pi_mod = AW'(pi_sum - {1'b0, ksel_reg});
        else
            pi_mod = AW'(pi_sum);
        if (g_sum >= {1'b0, ksel_reg})
            g_next = AW'(g_sum - {1'b0, ksel_reg});
        else
            g_next = AW'(g_sum);
        i_next  = i_reg + AW'(1);
        pi_next = bypass_reg ? i_next : pi_mod;
    end

    // Address for the bit shown next cycle; parks at 0 so ARM pre-reads bit 0.
    always_comb begin
        rd_addr[0] = '0;
        rd_addr[1] = '0;
        if (state_reg == S_OUT && !last_bit) begin
            rd_addr[0] = i_next;
            rd_addr[1] = pi_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            buf_mem[wr_addr] <= in_bit;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic rd_q;
            always_ff @(posedge clk) begin
                rd_q <= buf_mem[rd_addr[gi]];
            end
        end
    endgenerate

    assign ck         = g_rd[0].rd_q & active_reg;
    assign ckp        = g_rd[1].rd_q & active_reg;
    assign data_ready = data_ready_reg;
    assign active     = active_reg;

`ifdef INTLV_BYPASS_EN
    always_ff @(posedge clk) begin
        if (aclr)
            bypass_reg <= 1'b0;
        else if (state_reg == S_IDLE && accept)
            bypass_reg <= bypass;
    end
`else
    assign bypass_reg = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_reg      <= S_IDLE;
            ksel_reg       <= '0;
            g0_reg         <= '0;
            step_reg       <= '0;
            wr_cnt_reg     <= '0;
            i_reg          <= '0;
            pi_reg         <= '0;
            g_reg          <= '0;
            guard_cnt_reg  <= '0;
            data_ready_reg <= 1'b0;
            active_reg     <= 1'b0;
        end else begin
            data_ready_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        ksel_reg   <= K ? KSEL_1 : KSEL_0;
                        g0_reg     <= K ? G0_1 : G0_0;
                        step_reg   <= K ? STEP_1 : STEP_0;
                        wr_cnt_reg <= AW'(1);
                        state_reg  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (wr_cnt_reg == ksel_reg - AW'(1)) begin
                            wr_cnt_reg <= '0;
                            state_reg  <= S_ARM;
                        end else begin
                            wr_cnt_reg <= wr_cnt_reg + AW'(1);
                        end
                    end
                end
                S_ARM: begin
                    if (!enc_busy) begin
                        i_reg          <= '0;
                        pi_reg         <= '0;
                        g_reg          <= g0_reg;
                        data_ready_reg <= 1'b1;
                        active_reg     <= 1'b1;
                        state_reg      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (last_bit) begin
                        active_reg    <= 1'b0;
                        guard_cnt_reg <= '0;
                        state_reg     <= S_GUARD;
                    end else begin
                        i_reg  <= i_next;
                        pi_reg <= pi_next;
                        g_reg  <= g_next;
                    end
                end
                S_GUARD: begin
                    if (guard_cnt_reg == GW'(GUARD - 1)) begin
                        guard_cnt_reg <= '0;
                        state_reg     <= S_IDLE;
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + GW'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qpp_interleaver.sv
// Scoreboard bench for qpp_interleaver: driver pushes expected ck/ckp streams, a negedge monitor pops and checks.
module tb_qpp_interleaver;

    logic clk = 1'b0;
    logic aclr, K, in_bit, in_valid, in_ready, enc_busy;
    logic data_ready, ck, ckp, active, bypass;

    always #5 clk = ~clk;

    qpp_interleaver dut (
        .clk        (clk),
        .aclr       (aclr),
        .K          (K),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
`ifdef INTLV_BYPASS_EN
        .bypass     (bypass),
`endif
        .in_ready   (in_ready),
        .enc_busy   (enc_busy),
        .data_ready (data_ready),
        .ck         (ck),
        .ckp        (ckp),
        .active     (active)
    );

`ifdef INTLV_BYPASS_EN
    localparam bit HAS_BYP = 1'b1;
`else
    localparam bit HAS_BYP = 1'b0;
`endif

    typedef struct packed {
        logic first;
        logic ck;
        logic ckp;
    } exp_t;

    exp_t exp_q[$];
    int   len_q[$];
    bit   data_arr [0:1055];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int qpp(input int i, input int n, input int f1, input int f2);
        longint v;
        v = longint'(f1) * i + longint'(f2) * i * i;
        return int'(v % n);
    endfunction

    // Reference: expected output stream computed straight from pi(i) = (f1*i + f2*i^2) mod K.
    task automatic send_block(input bit k, input int gap_mode, input bit flip, input bit byp,
                              input int busy_hold);
        int n, f1, f2, idx, cyc, p;
        bit v;
        exp_t e;
        n  = k ? 16 : 1056;
        f1 = k ? 1 : 17;
        f2 = k ? 4 : 66;
        for (int i = 0; i < n; i++) begin
            p       = (byp && HAS_BYP) ? i : qpp(i, n, f1, f2);
            e.first = (i == 0);
            e.ck    = data_arr[i];
            e.ckp   = data_arr[p];
            exp_q.push_back(e);
        end
        len_q.push_back(n);
        enc_busy = (busy_hold > 0);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_bit   = data_arr[idx];
            K        = (flip && idx > 0) ? ~k : k;
            bypass   = byp;
            if (v && in_ready) idx++;
        end
        if (idx < n) check("load_timeout", 32'(idx), 32'(n));
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        K        = ~k;
        check("in_ready_after_load", 32'(in_ready), 32'd0);
        for (int c = 0; c < busy_hold; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("arm_wait", {29'd0, in_ready, data_ready, active}, 32'd0);
        end
        if (busy_hold > 0) begin
            enc_busy = 1'b0;
            @(negedge clk);
            check("busy_release", 32'(data_ready), 32'd1);
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Monitor: every active cycle consumes one expected bit; active runs are length-checked.
    initial begin
        int run_len;
        bit prev_act;
        exp_t e;
        int l;
        run_len  = 0;
        prev_act = 1'b0;
        forever begin
            @(negedge clk);
            if (aclr) begin
                exp_q.delete();
                len_q.delete();
                run_len  = 0;
                prev_act = 1'b0;
            end else begin
                if (active) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_bit", {29'd0, data_ready, ck, ckp}, {29'd0, e});
                    end
                    run_len++;
                end else begin
                    check("idle_out", {29'd0, data_ready, ck, ckp}, 32'd0);
                    if (prev_act) begin
                        if (len_q.size() == 0) begin
                            check("unexpected_run", 32'(run_len), 32'd0);
                        end else begin
                            l = len_q.pop_front();
                            check("active_len", 32'(run_len), 32'(l));
                        end
                        run_len = 0;
                    end
                end
                prev_act = active;
            end
        end
    end

    initial begin
        logic [15:0] pat;
        int w;
        aclr = 1'b1; K = 1'b0; in_bit = 1'b0; in_valid = 1'b0; enc_busy = 1'b0; bypass = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {27'd0, in_ready, data_ready, ck, ckp, active}, 32'd0);
        aclr = 1'b0;
        #1;
        check("reset_release", 32'(in_ready), 32'd1);

        pat = 16'hA5C3;
        for (int i = 0; i < 16; i++) data_arr[i] = pat[i];
        send_block(1'b1, 0, 1'b0, 1'b0, 0);
        $display("block K=1 pattern A5C3 issued");

        for (int i = 0; i < 1056; i++) data_arr[i] = 1'($urandom_range(0, 1));
        send_block(1'b0, 0, 1'b0, 1'b0, 0);
        $display("block K=0 random issued");

        for (int i = 0; i < 1056; i++) data_arr[i] = (i == 83) || (i == 298);
        send_block(1'b0, 0, 1'b0, 1'b0, 0);
        $display("block K=0 marks at 83/298 issued");

        for (int i = 0; i < 16; i++) data_arr[i] = 1'($urandom_range(0, 1));
        send_block(1'b1, 0, 1'b0, 1'b0, 20);
        $display("block K=1 enc_busy hold issued");

        for (int i = 0; i < 16; i++) data_arr[i] = 1'($urandom_range(0, 1));
        send_block(1'b1, 1, 1'b1, 1'b0, 0);
        $display("block K=1 gaps and K flip issued");

        for (int i = 0; i < 16; i++) data_arr[i] = pat[i];
        send_block(1'b1, 0, 1'b0, 1'b0, 0);
        repeat (7) @(negedge clk);
        aclr = 1'b1;
        @(negedge clk);
        check("abort_outputs", {27'd0, in_ready, data_ready, ck, ckp, active}, 32'd0);
        aclr = 1'b0;
        #1;
        check("abort_release", {27'd0, in_ready, data_ready, ck, ckp, active}, 32'h10);
        $display("block K=1 aborted at bit 7");

        for (int i = 0; i < 16; i++) data_arr[i] = 1'($urandom_range(0, 1));
        send_block(1'b1, 0, 1'b0, 1'b0, 0);
        $display("block K=1 after abort issued");

        for (int i = 0; i < 16; i++) data_arr[i] = 1'($urandom_range(0, 1));
        send_block(1'b1, 0, 1'b0, 1'b1, 0);
        $display("block K=1 bypass=1 issued");
        send_block(1'b1, 0, 1'b0, 1'b0, 0);
        $display("block K=1 bypass=0 issued");

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 16; i++) data_arr[i] = 1'($urandom_range(0, 1));
            send_block(1'b1, 2, 1'b0, 1'b0, 0);
            $display("block K=1 random gaps %0d issued", b);
        end

        w = 0;
        while ((exp_q.size() != 0 || active) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check("drain_exp", 32'(exp_q.size()), 32'd0);
        check("drain_len", 32'(len_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
